aoi22_pipe: RTL and testbench



---
 rtl/aoi22_pipe.sv | 146 ++++++++++++++
 tb/tb_aoi22_pipe.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aoi22_pipe.sv
// ---------------------------------------------------------------------------
// aoi22_pipe: WIDTH-bit AOI22/OAI22 bit-slice with a STAGES-deep elastic
// valid/ready register pipeline.
//
// The function is evaluated on the operands at acceptance, so the stages
// carry results rather than operands:
//   MODE=0 : ZN = ~((A1 & A2) | (B1 & B2))
//   MODE=1 : ZN = ~((A1 | A2) & (B1 | B2))
//
// Ports:
//   CK         clock, rising edge
//   RN         asynchronous active-low reset; empties the pipeline, zeroes ZN
//   in_valid   transaction offered upstream
//   in_ready   pipeline can accept this cycle
//   MODE       function select, captured with the operands
//   A1/A2/B1/B2  WIDTH-bit operands
//   out_valid  ZN holds a valid result
//   out_ready  downstream accepts the result
//   ZN         registered result
//   ZN_PAR     (only with AOI22_PIPE_PARITY_EN) XOR-reduction of the result,
//              carried through the same stages as ZN
//
// Optional feature macro: AOI22_PIPE_PARITY_EN
// ---------------------------------------------------------------------------
module aoi22_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ZN
`ifdef AOI22_PIPE_PARITY_EN
  ,
  output logic             ZN_PAR
`endif
);

  if (STAGES == 0 || STAGES > 4) begin : g_bad_stages
    $error("aoi22_pipe: STAGES must be in the range 1..4");
  end

  logic [WIDTH-1:0] func_res;

  // rdy[i] means stage i+1 may load this cycle; rdy[STAGES] is the sink.
  logic [STAGES:0]  rdy;

  logic [STAGES:1]  valid_q, valid_d;
  logic [WIDTH-1:0] data_q [1:STAGES];
  logic [WIDTH-1:0] data_d [1:STAGES];

  // Index 0 of these views is the combinational input side of stage 1.
  logic [STAGES:0]  up_valid;
  logic [WIDTH-1:0] up_data [0:STAGES];

  always_comb begin
    if (MODE) begin
      func_res = ~((A1 | A2) & (B1 | B2));
    end else begin
      func_res = ~((A1 & A2) | (B1 & B2));
    end
  end

  // A stage can load if it is empty or its own content is moving on, so a
  // bubble anywhere lets everything upstream of it advance.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int i = int'(STAGES); i >= 1; i--) begin
      rdy[i-1] = ~valid_q[i] | rdy[i];
    end
  end

  always_comb begin
    up_valid   = {valid_q, in_valid};
    up_data[0] = func_res;
    for (int i = 1; i <= int'(STAGES); i++) begin
      up_data[i] = data_q[i];
    end
  end

  // Data only moves with a valid token, so idle operands never reach state.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 1; i <= int'(STAGES); i++) begin
      if (rdy[i-1]) begin
        valid_d[i] = up_valid[i-1];
        if (up_valid[i-1]) begin
          data_d[i] = up_data[i-1];
        end
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      valid_q <= '0;
      for (int i = 1; i <= int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES];
  assign ZN        = data_q[STAGES];

`ifdef AOI22_PIPE_PARITY_EN
  logic [STAGES:1] par_q, par_d;
  logic [STAGES:0] up_par;

  // Parity rides alongside the data and follows the same load enables.
  always_comb begin
    up_par = {par_q, ^func_res};
    par_d  = par_q;
    for (int i = 1; i <= int'(STAGES); i++) begin
      if (rdy[i-1] && up_valid[i-1]) begin
        par_d[i] = up_par[i-1];
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign ZN_PAR = par_q[STAGES];
`endif

endmodule

// File: tb/tb_aoi22_pipe.sv
// ---------------------------------------------------------------------------
// Self-checking bench for aoi22_pipe. A transaction-level model (a queue of
// accepted results, each with the earliest cycle it may appear at the output)
// is checked every cycle, and scenario tasks make directed checks.
// ---------------------------------------------------------------------------
module tb_aoi22_pipe;

  localparam int unsigned W = 4;
  localparam int unsigned S = 2;

  logic         ck        = 1'b0;
  logic         rn        = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic         mode      = 1'b0;
  logic [W-1:0] a1        = '0;
  logic [W-1:0] a2        = '0;
  logic [W-1:0] b1        = '0;
  logic [W-1:0] b2        = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] zn;
`ifdef AOI22_PIPE_PARITY_EN
  logic         zn_par;
`endif

  int n_vec = 0;
  int n_err = 0;

  aoi22_pipe #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .CK       (ck),
    .RN       (rn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .MODE     (mode),
    .A1       (a1),
    .A2       (a2),
    .B1       (b1),
    .B2       (b2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ZN       (zn)
`ifdef AOI22_PIPE_PARITY_EN
    ,
    .ZN_PAR   (zn_par)
`endif
  );

  always #5 ck = ~ck;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_zn(input logic m, input logic [W-1:0] x1,
                                          input logic [W-1:0] x2, input logic [W-1:0] y1,
                                          input logic [W-1:0] y2);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) begin
      if (!m) r[i] = !((x1[i] && x2[i]) || (y1[i] && y2[i]));
      else    r[i] = !((x1[i] || x2[i]) && (y1[i] || y2[i]));
    end
    return r;
  endfunction

  function automatic logic ref_par(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < int'(W); i++) if (v[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  typedef struct {
    logic [W-1:0] res;
    logic         par;
    int           rdy;   // first cycle count at which it may be at the output
  } item_t;

  item_t mq[$];
  int    cyc = 0;
  bit    m_vis, m_rdy, m_xfer, m_acc;
  item_t m_it;

  // Capacity S, one result per cycle, no bubbles: an item reaches the output
  // S-1 edges after its acceptance edge, or at the edge its predecessor leaves.
  always @(posedge ck or negedge rn) begin
    if (!rn) begin
      mq.delete();
    end else begin
      m_vis  = (mq.size() > 0) && (mq[0].rdy <= cyc);
      m_rdy  = (mq.size() < int'(S)) || out_ready;
      m_xfer = m_vis && out_ready;
      m_acc  = in_valid && m_rdy;
      cyc++;
      if (m_xfer) begin
        void'(mq.pop_front());
        if (mq.size() > 0 && mq[0].rdy < cyc) mq[0].rdy = cyc;
      end
      if (m_acc) begin
        m_it.res = ref_zn(mode, a1, a2, b1, b2);
        m_it.par = ref_par(m_it.res);
        m_it.rdy = cyc + int'(S) - 1;
        mq.push_back(m_it);
      end
    end
  end

  bit mon_vis, mon_rdy;
  always @(negedge ck) begin
    mon_vis = (mq.size() > 0) && (mq[0].rdy <= cyc);
    mon_rdy = (mq.size() < int'(S)) || out_ready;
    n_vec++;
    if (in_ready !== mon_rdy) begin
      n_err++;
      $display("FAIL mon_in_ready t=%0t got %b expected %b", $time, in_ready, mon_rdy);
    end
    n_vec++;
    if (out_valid !== mon_vis) begin
      n_err++;
      $display("FAIL mon_out_valid t=%0t got %b expected %b", $time, out_valid, mon_vis);
    end
    if (mon_vis) begin
      n_vec++;
      if (zn !== mq[0].res) begin
        n_err++;
        $display("FAIL mon_zn t=%0t got %b expected %b", $time, zn, mq[0].res);
      end
`ifdef AOI22_PIPE_PARITY_EN
      n_vec++;
      if (zn_par !== mq[0].par) begin
        n_err++;
        $display("FAIL mon_zn_par t=%0t got %b expected %b", $time, zn_par, mq[0].par);
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic set_in(input logic v, input logic m, input logic [W-1:0] x1,
                        input logic [W-1:0] x2, input logic [W-1:0] y1,
                        input logic [W-1:0] y2);
    in_valid = v;
    mode     = m;
    a1       = x1;
    a2       = x2;
    b1       = y1;
    b2       = y2;
  endtask

  task automatic set_rand(input logic v);
    set_in(v, 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_rand(1'($urandom));
      out_ready = 1'($urandom);
      @(negedge ck);
      n_vec++;
      if (out_valid !== 1'b0 || zn !== '0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state got ov=%b zn=%b ir=%b expected ov=0 zn=0000 ir=1",
                 out_valid, zn, in_ready);
      end
    end
    next_cyc();
    rn = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ck);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d got out_valid=%b expected 0", c, out_valid);
      end
    end
  endtask

  task automatic test_single(input logic m, input logic [W-1:0] exp_zn, input string name);
    next_cyc();
    out_ready = 1'b1;
    set_in(1'b1, m, 4'b1100, 4'b1010, 4'b0011, 4'b0101);
    next_cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= int'(S); k++) begin
      @(negedge ck);
      n_vec++;
      if (k < int'(S)) begin
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s_latency cycle %0d got out_valid=%b expected 0", name, k, out_valid);
        end
      end else if (out_valid !== 1'b1 || zn !== exp_zn) begin
        n_err++;
        $display("FAIL %s_result got ov=%b zn=%b expected ov=1 zn=%b",
                 name, out_valid, zn, exp_zn);
      end
`ifdef AOI22_PIPE_PARITY_EN
      if (k == int'(S)) begin
        n_vec++;
        if (zn_par !== 1'b0) begin
          n_err++;
          $display("FAIL %s_parity got %b expected 0", name, zn_par);
        end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got[$];
    int first = -1;
    int last  = -1;
    next_cyc();
    out_ready = 1'b1;
    set_in(1'b1, 1'b0, 4'b1100, 4'b1010, 4'b0011, 4'b0101);
    for (int c = 0; c < 20; c++) begin
      @(negedge ck);
      if (out_valid) begin
        got.push_back(zn);
        if (first < 0) first = c;
        last = c;
      end
      next_cyc();
      if (c + 1 < 8) mode = 1'((c + 1) % 2);
      else in_valid = 1'b0;
    end
    n_vec++;
    if (got.size() != 8 || last - first != 7) begin
      n_err++;
      $display("FAIL b2b_count got %0d results over %0d cycles expected 8 over 8",
               got.size(), last - first + 1);
    end
    foreach (got[i]) begin
      n_vec++;
      if (got[i] !== ((i % 2) ? 4'b1001 : 4'b0110)) begin
        n_err++;
        $display("FAIL b2b_order idx %0d got %b expected %b", i, got[i],
                 (i % 2) ? 4'b1001 : 4'b0110);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] opa1[6], opa2[6], opb1[6], opb2[6], exp[6];
    logic         opm[6];
    logic [W-1:0] got[$];
    int   n_acc = 0;
    bit   acc;
    for (int i = 0; i < 6; i++) begin
      opm[i]  = 1'($urandom);
      opa1[i] = W'($urandom);
      opa2[i] = W'($urandom);
      opb1[i] = W'($urandom);
      opb2[i] = W'($urandom);
      exp[i]  = ref_zn(opm[i], opa1[i], opa2[i], opb1[i], opb2[i]);
    end
    next_cyc();
    out_ready = 1'b0;
    set_in(1'b1, opm[0], opa1[0], opa2[0], opb1[0], opb2[0]);
    for (int c = 0; c < 60; c++) begin
      @(negedge ck);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(zn);
      if (c == 6) begin
        n_vec++;
        if (n_acc != int'(S) || in_ready !== 1'b0 || out_valid !== 1'b1 || zn !== exp[0]) begin
          n_err++;
          $display("FAIL bp_stall got acc=%0d ir=%b ov=%b zn=%b expected acc=%0d ir=0 ov=1 zn=%b",
                   n_acc, in_ready, out_valid, zn, S, exp[0]);
        end
      end
      next_cyc();
      if (acc) n_acc++;
      if (n_acc < 6) set_in(1'b1, opm[n_acc], opa1[n_acc], opa2[n_acc], opb1[n_acc], opb2[n_acc]);
      else in_valid = 1'b0;
      if (c == 6) out_ready = 1'b1;
    end
    n_vec++;
    if (got.size() != 6) begin
      n_err++;
      $display("FAIL bp_count got %0d results expected 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_vec++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL bp_order idx %0d got %b expected %b", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_bubble();
    logic [W-1:0] r1, r2;
    next_cyc();
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 4'b1111, 4'b0101, 4'b0000, 4'b0000);
    r1 = ref_zn(1'b0, 4'b1111, 4'b0101, 4'b0000, 4'b0000);
    next_cyc();
    in_valid = 1'b0;
    next_cyc();
    set_in(1'b1, 1'b1, 4'b0001, 4'b0010, 4'b0100, 4'b0000);
    r2 = ref_zn(1'b1, 4'b0001, 4'b0010, 4'b0100, 4'b0000);
    next_cyc();
    in_valid = 1'b0;
    @(negedge ck);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || zn !== r1) begin
      n_err++;
      $display("FAIL bubble_full got ov=%b ir=%b zn=%b expected ov=1 ir=0 zn=%b",
               out_valid, in_ready, zn, r1);
    end
    next_cyc();
    out_ready = 1'b1;
    @(negedge ck);
    @(negedge ck);
    n_vec++;
    if (out_valid !== 1'b1 || zn !== r2) begin
      n_err++;
      $display("FAIL bubble_second got ov=%b zn=%b expected ov=1 zn=%b", out_valid, zn, r2);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] r3;
    next_cyc();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) next_cyc();
    set_rand(1'b1);
    next_cyc();
    set_rand(1'b1);
    next_cyc();
    in_valid = 1'b0;
    @(negedge ck);
    #1;
    rn = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || zn !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_clear got ov=%b zn=%b ir=%b expected ov=0 zn=0000 ir=1",
               out_valid, zn, in_ready);
    end
    #2;
    rn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ck);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_ghost cycle %0d got out_valid=%b expected 0", c, out_valid);
      end
    end
    next_cyc();
    set_in(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b0011, 4'b0001);
    r3 = ref_zn(1'b1, 4'b1000, 4'b0000, 4'b0011, 4'b0001);
    next_cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= int'(S); k++) begin
      @(negedge ck);
      n_vec++;
      if ((k < int'(S) && out_valid !== 1'b0) ||
          (k == int'(S) && (out_valid !== 1'b1 || zn !== r3))) begin
        n_err++;
        $display("FAIL midrst_latency cycle %0d got ov=%b zn=%b expected ov=%b zn=%b",
                 k, out_valid, zn, k == int'(S), r3);
      end
    end
  endtask

  task automatic test_random_stream();
    int  n_acc = 0;
    int  n_out = 0;
    bit  acc;
    next_cyc();
    for (int c = 0; c < 300; c++) begin
      set_rand(($urandom % 10) < 6);
      out_ready = ($urandom % 10) < 7;
      @(negedge ck);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) n_out++;
      next_cyc();
      if (acc) n_acc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ck);
      if (out_valid && out_ready) n_out++;
      next_cyc();
    end
    n_vec++;
    if (n_out != n_acc) begin
      n_err++;
      $display("FAIL rand_conservation got %0d results expected %0d", n_out, n_acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(1'b0, 4'b0110, "aoi");
    test_single(1'b1, 4'b1001, "oai");
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_mid_reset();
    test_random_stream();
    @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
